// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : start / 8 data (LSB first) / even-XOR parity / stop UART receiver
// Rev 1.0
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam int START_CNT = (HALF > 0) ? HALF - 1 : 0;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] START_AT = CNT_W'(START_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift;
  logic                   par_bit;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge clk) begin
        if (reset) sync <= 1'b1;
        else       sync <= rx;
      end
    end else begin : g_sync_chain
      always_ff @(posedge clk) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], rx};
      end
    end
  endgenerate

  assign rx_s = sync[SYNC_STAGES-1];

  // cnt counts cycles since the last state change; each later sample lands
  // one full bit period after the previous one, i.e. at cnt == BIT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      cnt        <= cnt + CNT_ONE;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            busy    <= 1'b1;
            bit_idx <= '0;
            // With HALF == 0 the start sample is this very cycle and is known low.
            state   <= (HALF == 0) ? DATA : START;
          end
        end
        START: begin
          if (cnt == START_AT) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            data_out   <= shift;
            data_valid <= 1'b1;
            parity_err <= ^{shift, par_bit};
            frame_err  <= ~rx_s;
            busy       <= 1'b0;
            state      <= rx_s ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Directed bench for uart_rx: one instance at 1 clk/bit, one at 16 clks/bit.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx16 = 1'b1;
  logic [7:0] data_out1, data_out16;
  logic       dv1, dv16, perr1, perr16, ferr1, ferr16, busy1, busy16;

  int passed = 0;
  int total = 0;
  int cycle = 0;
  int start_cyc = 0;
  int pulses1 = 0, pulses16 = 0, err_pulses1 = 0, long1 = 0, leak = 0;
  int last_cyc1 = 0, prev_cyc1 = 0, last_cyc16 = 0;
  logic [7:0] last_d1 = 8'h0, prev_d1 = 8'h0, last_d16 = 8'h0;
  logic last_pe1 = 1'b0, last_fe1 = 1'b0, last_pe16 = 1'b0, last_fe16 = 1'b0;
  logic dv1_q = 1'b0;

  uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .data_out(data_out1), .data_valid(dv1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .rx(rx16), .data_out(data_out16), .data_valid(dv16),
    .parity_err(perr16), .frame_err(ferr16), .busy(busy16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (dv1) begin
      if (dv1_q) long1++;
      pulses1++;
      prev_cyc1 = last_cyc1;
      last_cyc1 = cycle;
      prev_d1   = last_d1;
      last_d1   = data_out1;
      last_pe1  = perr1;
      last_fe1  = ferr1;
      if (perr1 || ferr1) err_pulses1++;
    end
    if (dv16) begin
      pulses16++;
      last_cyc16 = cycle;
      last_d16   = data_out16;
      last_pe16  = perr16;
      last_fe16  = ferr16;
    end
    if ((!dv1 && (perr1 || ferr1)) || (!dv16 && (perr16 || ferr16))) leak++;
    dv1_q = dv1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int cpb, input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (cpb == 1) rx1 = v; else rx16 = v;
    end
  endtask

  task automatic frame(input int cpb, input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      for (int j = 0; j < cpb; j++) begin
        @(posedge clk); #1;
        if (k == 0 && j == 0) start_cyc = cycle;
        if (cpb == 1) rx1 = bits[k]; else rx16 = bits[k];
      end
    end
  endtask

  initial begin
    int p0, e0;
    logic [10:0] fb;

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_data_out", data_out1, 8'h00);
    chk("rst_valid", dv1, 1'b0);
    chk("rst_perr", perr1, 1'b0);
    chk("rst_ferr", ferr1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_busy16", busy16, 1'b0);

    // 0xA5, good parity and stop
    drive(1, 1'b1, 2);
    p0 = pulses1;
    frame(1, 8'hA5, 1'b0, 1'b1);
    @(negedge clk);
    chk("a5_busy_mid", busy1, 1'b1);
    drive(1, 1'b1, 6);
    chk("a5_pulses", pulses1 - p0, 1);
    chk("a5_data", last_d1, 8'hA5);
    chk("a5_perr", last_pe1, 1'b0);
    chk("a5_ferr", last_fe1, 1'b0);
    chk("a5_latency", last_cyc1 - start_cyc, 13);
    chk("a5_busy_after", busy1, 1'b0);

    // 0x3C with wrong parity bit
    p0 = pulses1;
    frame(1, 8'h3C, 1'b1, 1'b1);
    drive(1, 1'b1, 6);
    chk("3c_pulses", pulses1 - p0, 1);
    chk("3c_data", last_d1, 8'h3C);
    chk("3c_perr", last_pe1, 1'b1);
    chk("3c_ferr", last_fe1, 1'b0);

    // 0x81 with stop=0, line held low, then recovery frame 0x55
    p0 = pulses1;
    frame(1, 8'h81, 1'b0, 1'b0);
    drive(1, 1'b0, 20);
    chk("brk_pulses", pulses1 - p0, 1);
    chk("brk_data", last_d1, 8'h81);
    chk("brk_ferr", last_fe1, 1'b1);
    chk("brk_perr", last_pe1, 1'b0);
    chk("brk_busy", busy1, 1'b0);
    drive(1, 1'b1, 4);
    frame(1, 8'h55, 1'b0, 1'b1);
    drive(1, 1'b1, 6);
    chk("rec_pulses", pulses1 - p0, 2);
    chk("rec_data", last_d1, 8'h55);
    chk("rec_perr", last_pe1, 1'b0);
    chk("rec_ferr", last_fe1, 1'b0);

    // back-to-back 0x00 then 0xFF, zero idle gap
    p0 = pulses1;
    e0 = err_pulses1;
    frame(1, 8'h00, 1'b0, 1'b1);
    frame(1, 8'hFF, 1'b0, 1'b1);
    drive(1, 1'b1, 6);
    chk("b2b_pulses", pulses1 - p0, 2);
    chk("b2b_spacing", last_cyc1 - prev_cyc1, 11);
    chk("b2b_first", prev_d1, 8'h00);
    chk("b2b_second", last_d1, 8'hFF);
    chk("b2b_errs", err_pulses1 - e0, 0);

    // 16 clk/bit: false start of 3 low cycles
    p0 = pulses16;
    drive(16, 1'b0, 3);
    @(posedge clk); #1 rx16 = 1'b1;
    @(negedge clk);
    chk("fs_busy_high", busy16, 1'b1);
    drive(16, 1'b1, 20);
    @(negedge clk);
    chk("fs_busy_low", busy16, 1'b0);
    chk("fs_no_valid", pulses16 - p0, 0);

    // 16 clk/bit: clean 0xA5 after the false start
    frame(16, 8'hA5, 1'b0, 1'b1);
    drive(16, 1'b1, 24);
    chk("s16_pulses", pulses16 - p0, 1);
    chk("s16_data", last_d16, 8'hA5);
    chk("s16_perr", last_pe16, 1'b0);
    chk("s16_ferr", last_fe16, 1'b0);
    chk("s16_latency", last_cyc16 - start_cyc, 170);

    // reset during data bit 4 of 0x12, then a clean 0x12
    p0 = pulses1;
    fb = {1'b1, 1'b0, 8'h12, 1'b0};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1 rx1 = fb[k];
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rx1 = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mr_busy", busy1, 1'b0);
    chk("mr_data_out", data_out1, 8'h00);
    chk("mr_data_out16", data_out16, 8'h00);
    drive(1, 1'b1, 20);
    chk("mr_no_valid", pulses1 - p0, 0);
    frame(1, 8'h12, 1'b0, 1'b1);
    drive(1, 1'b1, 6);
    chk("mr_pulses", pulses1 - p0, 1);
    chk("mr_data", last_d1, 8'h12);
    chk("mr_perr", last_pe1, 1'b0);
    chk("mr_ferr", last_fe1, 1'b0);

    chk("valid_width", long1, 0);
    chk("flag_qualify", leak, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
